apu_reg_interface: RTL and testbench

//  CPU-side register front end of the NES APU: decodes CPU bus accesses to $4000-$4017 and

---
 rtl/apu_reg_interface.sv | 82 ++++++++
 tb/tb_apu_reg_interface.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apu_reg_interface.sv
// rtl/apu_reg_interface.sv - APU $4000-$4017 register front end with per-register write strobes.
// Optional $4015 status read-back is built only when APU_STATUS_READ_EN is defined.
module apu_reg_interface #(
    parameter int NUM_REGS    = 24,
    parameter int ADDR_WIDTH  = 5,
    parameter int STATUS_ADDR = 21
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic                  iCs,
    input  logic                  iRw,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [7:0]            iData,
    input  logic [3:0]            iLen_status,
    input  logic                  iDmc_active,
    input  logic                  iFrame_irq,
    input  logic                  iDmc_irq,
    output logic [NUM_REGS*8-1:0] oRegs,
    output logic [NUM_REGS-1:0]   oWr,
    output logic [7:0]            oData,
    output logic                  oFrame_irq_clr
);

    logic                cs_d;
    logic                start;
    logic [NUM_REGS-1:0] wr_hit;

    // A CPU access may hold iCs for many cycles; only its first cycle acts.
    assign start = iCs & ~cs_d;

    // Out-of-range offsets match no decode entry and are dropped naturally.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_hit[k] = start & ~iRw & (iAddr == ADDR_WIDTH'(k));
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            cs_d  <= 1'b0;
            oRegs <= '0;
            oWr   <= '0;
        end else begin
            cs_d <= iCs;
            oWr  <= wr_hit;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit[k]) begin
                    oRegs[8*k +: 8] <= iData;
                end
            end
        end
    end

`ifdef APU_STATUS_READ_EN
    logic       status_hit;
    logic [7:0] status_byte;

    assign status_hit  = (iAddr == ADDR_WIDTH'(STATUS_ADDR));
    assign status_byte = {iDmc_irq, iFrame_irq, 1'b0, iDmc_active, iLen_status};

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData          <= 8'h00;
            oFrame_irq_clr <= 1'b0;
        end else begin
            oFrame_irq_clr <= 1'b0;
            if (start && iRw) begin
                oData          <= status_hit ? status_byte : 8'h00;
                oFrame_irq_clr <= status_hit;
            end
        end
    end
`else
    logic unused_status;

    assign unused_status  = ^{iLen_status, iDmc_active, iFrame_irq, iDmc_irq};
    assign oData          = 8'h00;
    assign oFrame_irq_clr = 1'b0;
`endif

endmodule

// File: tb/tb_apu_reg_interface.sv
// tb/tb_apu_reg_interface.sv - directed table-driven bench for apu_reg_interface.
module tb_apu_reg_interface;

    localparam int NR = 24;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic          rw;
    logic [4:0]    addr;
    logic [7:0]    data;
    logic [3:0]    len_status;
    logic          dmc_active;
    logic          frame_irq;
    logic          dmc_irq;
    logic [NR*8-1:0] regs;
    logic [NR-1:0] wr;
    logic [7:0]    rdata;
    logic          irq_clr;

    int checks = 0;
    int errors = 0;

    apu_reg_interface #(.NUM_REGS(NR), .ADDR_WIDTH(5), .STATUS_ADDR(21)) dut (
        .iClk           (clk),
        .iReset_n       (rst_n),
        .iCs            (cs),
        .iRw            (rw),
        .iAddr          (addr),
        .iData          (data),
        .iLen_status    (len_status),
        .iDmc_active    (dmc_active),
        .iFrame_irq     (frame_irq),
        .iDmc_irq       (dmc_irq),
        .oRegs          (regs),
        .oWr            (wr),
        .oData          (rdata),
        .oFrame_irq_clr (irq_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          cs;
        logic          rw;
        logic [4:0]    addr;
        logic [7:0]    data;
        logic [NR-1:0] exp_wr;
        int            chk;
        logic [7:0]    exp_reg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic r, logic [4:0] a, logic [7:0] d,
                                logic [NR-1:0] w, int k, logic [7:0] e);
        vec_t v;
        v.cs = c; v.rw = r; v.addr = a; v.data = d;
        v.exp_wr = w; v.chk = k; v.exp_reg = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [NR*8-1:0] act, input logic [NR*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic r, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = c; rw = r; addr = a; data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] bit_at(int k);
        logic [NR-1:0] b;
        b = '0;
        b[k] = 1'b1;
        return b;
    endfunction

    logic [NR*8-1:0] exp_regs;
    logic [7:0]      exp_status;
    logic            exp_clr;

    initial begin
        rst_n = 1'b0; cs = 1'b0; rw = 1'b0; addr = '0; data = '0;
        len_status = '0; dmc_active = 1'b0; frame_irq = 1'b0; dmc_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_regs", regs, '0);
        check("reset_wr", {168'd0, wr}, '0);
        check("reset_data", {184'd0, rdata}, '0);
        check("reset_clr", {191'd0, irq_clr}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // write 11 with iCs held 4 cycles
        vecs.push_back(mk(1, 0, 11, 8'hF8, bit_at(11), 11, 8'hF8));
        vecs.push_back(mk(1, 0, 11, 8'hF8, '0, 11, 8'hF8));
        vecs.push_back(mk(1, 0, 11, 8'hF8, '0, 11, 8'hF8));
        vecs.push_back(mk(1, 0, 11, 8'hF8, '0, 11, 8'hF8));
        vecs.push_back(mk(0, 0, 11, 8'hF8, '0, 11, 8'hF8));
        // triangle registers back-to-back with one idle cycle
        vecs.push_back(mk(1, 0, 8, 8'h81, bit_at(8), 8, 8'h81));
        vecs.push_back(mk(0, 0, 8, 8'h81, '0, 8, 8'h81));
        vecs.push_back(mk(1, 0, 10, 8'hFD, bit_at(10), 10, 8'hFD));
        vecs.push_back(mk(0, 0, 10, 8'hFD, '0, 10, 8'hFD));
        vecs.push_back(mk(1, 0, 11, 8'h08, bit_at(11), 11, 8'h08));
        vecs.push_back(mk(0, 0, 11, 8'h08, '0, 11, 8'h08));
        // out-of-range addresses
        vecs.push_back(mk(1, 0, 24, 8'hAA, '0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 24, 8'hAA, '0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 31, 8'h55, '0, 23, 8'h00));
        vecs.push_back(mk(0, 0, 31, 8'h55, '0, 23, 8'h00));
        // address change during held write
        vecs.push_back(mk(1, 0, 3, 8'h33, bit_at(3), 3, 8'h33));
        vecs.push_back(mk(1, 0, 5, 8'h55, '0, 5, 8'h00));
        vecs.push_back(mk(1, 0, 5, 8'h5A, '0, 3, 8'h33));
        vecs.push_back(mk(0, 0, 5, 8'h5A, '0, 5, 8'h00));
        // read start leaves registers alone
        vecs.push_back(mk(1, 1, 3, 8'h99, '0, 3, 8'h33));
        vecs.push_back(mk(0, 1, 3, 8'h99, '0, 3, 8'h33));
        // write to $4017 offset
        vecs.push_back(mk(1, 0, 23, 8'hC0, bit_at(23), 23, 8'hC0));
        vecs.push_back(mk(0, 0, 23, 8'hC0, '0, 23, 8'hC0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_wr", i), {168'd0, wr}, {168'd0, vecs[i].exp_wr});
            check($sformatf("vec%0d_reg%0d", i, vecs[i].chk),
                  {184'd0, regs[8*vecs[i].chk +: 8]}, {184'd0, vecs[i].exp_reg});
            check($sformatf("vec%0d_clr", i), {191'd0, irq_clr}, '0);
        end

        exp_regs = '0;
        exp_regs[8*3 +: 8]  = 8'h33;
        exp_regs[8*8 +: 8]  = 8'h81;
        exp_regs[8*10 +: 8] = 8'hFD;
        exp_regs[8*11 +: 8] = 8'h08;
        exp_regs[8*23 +: 8] = 8'hC0;
        check("all_regs", regs, exp_regs);

`ifdef APU_STATUS_READ_EN
        exp_status = 8'h45;
        exp_clr    = 1'b1;
`else
        exp_status = 8'h00;
        exp_clr    = 1'b0;
`endif
        // status read with iCs held 2 cycles
        len_status = 4'b0101; frame_irq = 1'b1; dmc_active = 1'b0; dmc_irq = 1'b0;
        drive(1, 1, 21, 8'h00);
        check("status_data", {184'd0, rdata}, {184'd0, exp_status});
        check("status_clr", {191'd0, irq_clr}, {191'd0, exp_clr});
        drive(1, 1, 21, 8'h00);
        check("status_clr_once", {191'd0, irq_clr}, '0);
        check("status_hold", {184'd0, rdata}, {184'd0, exp_status});
        drive(0, 1, 21, 8'h00);
        drive(1, 0, 0, 8'h00);
        check("status_hold_wr", {184'd0, rdata}, {184'd0, exp_status});
        check("status_wr_strobe", {168'd0, wr}, {168'd0, bit_at(0)});
        drive(0, 0, 0, 8'h00);
        drive(1, 1, 3, 8'h00);
        check("read3_data", {184'd0, rdata}, '0);
        check("read3_clr", {191'd0, irq_clr}, '0);
        drive(0, 1, 3, 8'h00);

        // reset in the middle of a held write
        drive(1, 0, 7, 8'h77);
        check("pre_rst_wr", {168'd0, wr}, {168'd0, bit_at(7)});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_regs", regs, '0);
        check("rst_async_wr", {168'd0, wr}, '0);
        check("rst_async_data", {184'd0, rdata}, '0);
        check("rst_async_clr", {191'd0, irq_clr}, '0);
        addr = 9; data = 8'h99;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_wr", {168'd0, wr}, {168'd0, bit_at(9)});
        exp_regs = '0;
        exp_regs[8*9 +: 8] = 8'h99;
        check("rel_regs", regs, exp_regs);
        drive(1, 0, 9, 8'h99);
        check("rel_no_repeat", {168'd0, wr}, '0);
        drive(0, 0, 9, 8'h99);
        check("rel_idle", {168'd0, wr}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
